decimal_keypad_debounce: RTL and testbench

- Front end for the 10-line decimal-to-BCD encoder.
- Takes raw, asynchronous, bouncing key lines from a 10-key decimal pad, synchronises and debounces them.
- Rejects multi-key presses.
- Presents a stable one-hot key vector plus an enable that drive the encoder's `in` and `enable` directly.
- Also emits a single-cycle strobe per accepted key press, for downstream digit capture.

---
 rtl/decimal_keypad_debounce_pkg.sv | 20 ++
 rtl/decimal_keypad_debounce_sync2.sv | 26 ++
 rtl/decimal_keypad_debounce.sv | 122 ++++++++++++
 tb/tb_decimal_keypad_debounce.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_keypad_debounce_pkg.sv
// Shared types and helpers for the decimal keypad front end.
package keypad_pkg;

    localparam int NUM_KEYS = 10;

    typedef logic [NUM_KEYS-1:0] keys_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // True when exactly one key line is set.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/decimal_keypad_debounce_sync2.sv
// Two-flop synchroniser for asynchronous inputs, parameterised width.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/decimal_keypad_debounce.sv
// Synchronises, debounces and single-key-filters a 10-line decimal pad,
// producing a one-hot vector, enable and press strobe for the BCD encoder.
module decimal_keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic                key_valid,
    output logic                key_strobe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    keys_t            key_sync;
    logic             onehot_ok;

    state_t           state_q,  state_d;
    keys_t            cand_q,   cand_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    keys_t            onehot_q, onehot_d;
    logic             valid_q,  valid_d;
    logic             strobe_q, strobe_d;

    sync2 #(
        .W (NUM_KEYS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_raw),
        .q   (key_sync)
    );

    assign onehot_ok = is_onehot(key_sync);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (onehot_ok) begin
                    cand_d  = key_sync;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (key_sync != cand_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_PRESSED;
                    onehot_d = cand_q;
                    valid_d  = 1'b1;
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_PRESSED: begin
                if (key_sync != cand_q) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end

            // Only a clean all-zero release ends a press; another key restarts the wait.
            ST_RELEASE: begin
                if (key_sync == cand_q) begin
                    state_d = ST_PRESSED;
                end else if (key_sync == '0) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_IDLE;
                        onehot_d = '0;
                        valid_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
        end
    end

    assign key_onehot = onehot_q;
    assign key_valid  = valid_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_decimal_keypad_debounce.sv
// Bench for decimal_keypad_debounce: vector table, corner sequences, strobe scoreboard.
module tb_decimal_keypad_debounce;

    localparam int LAT = 7;

    logic       clk;
    logic       rst;
    logic [9:0] key_raw;
    logic [9:0] key_onehot;
    logic       key_valid;
    logic       key_strobe;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        logic [9:0] oh;
        int         at;
    } exp_t;

    typedef struct {
        logic [9:0] key;
        int         hold;
        logic [9:0] exp_oh;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    decimal_keypad_debounce dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_strobe (key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic logic [3:0] bcd(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd15;
        for (int i = 0; i < 10; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic ok_onehot(input logic [9:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) if (v[i]) n++;
        return n <= 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input logic [9:0] oh, input int at);
        exp_t e;
        e.oh = oh;
        e.at = at;
        sb.push_back(e);
    endtask

    // Strobe scoreboard plus output invariants, sampled away from the edge
    always @(negedge clk) begin
        exp_t e;
        if (key_strobe) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", 32'(key_onehot), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("strobe_onehot", 32'(key_onehot), 32'(e.oh));
                chk("strobe_cycle", 32'(cyc), 32'(e.at));
            end
        end
        chk("inv_onehot", 32'(ok_onehot(key_onehot)), 32'd1);
        chk("inv_valid", 32'(key_valid), 32'(key_onehot != 10'd0));
        chk("inv_strobe", 32'(key_strobe && !key_valid), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        logic       stay_ok;
        logic [9:0] k9, k6, k3, k1, k4;
        k9 = 10'b1000000000;
        k6 = 10'b0001000000;
        k3 = 10'b0000001000;
        k1 = 10'b0000000010;
        k4 = 10'b0000010000;

        vecs[0] = '{10'b1000000000, 12, 10'b1000000000};
        vecs[1] = '{10'b0000010001, 20, 10'b0000000000};
        vecs[2] = '{10'b0000000001,  8, 10'b0000000001};
        vecs[3] = '{10'b0000000100,  4, 10'b0000000000};
        vecs[4] = '{10'b0000000100,  5, 10'b0000000100};
        vecs[5] = '{10'b1100000000, 10, 10'b0000000000};
        vecs[6] = '{10'b0010000000,  6, 10'b0010000000};
        vecs[7] = '{10'b1111111111,  8, 10'b0000000000};

        // Reset with a key held
        rst     = 1'b1;
        key_raw = k9;
        #1;
        chk("rst_onehot", 32'(key_onehot), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_strobe", 32'(key_strobe), 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", 32'({key_onehot, key_valid, key_strobe}), 32'h0);
        end
        key_raw = '0;
        rst     = 1'b0;
        tick(3);

        // Clean press of key 9
        t = cyc;
        key_raw = k9;
        expect_press(k9, t + LAT);
        tick(LAT - 1);
        chk("k9_valid_early", 32'(key_valid), 32'h0);
        tick(1);
        chk("k9_valid", 32'(key_valid), 32'h1);
        chk("k9_onehot", 32'(key_onehot), 32'(k9));
        chk("k9_strobe", 32'(key_strobe), 32'h1);
        chk("k9_bcd", 32'(bcd(key_onehot)), 32'd9);
        tick(1);
        chk("k9_strobe_off", 32'(key_strobe), 32'h0);
        chk("k9_valid_hold", 32'(key_valid), 32'h1);
        tick(4);
        key_raw = '0;
        t = cyc;
        tick(LAT - 1);
        chk("k9_rel_early", 32'(key_valid), 32'h1);
        tick(1);
        chk("k9_rel_valid", 32'(key_valid), 32'h0);
        chk("k9_rel_onehot", 32'(key_onehot), 32'h0);
        tick(4);
        chk("k9_drain", 32'(sb.size()), 32'd0);

        // Bouncing key 6
        for (int i = 0; i < 4; i++) begin
            key_raw = (i % 2 == 0) ? k6 : 10'd0;
            tick(2);
            chk("bounce_no_valid", 32'(key_valid), 32'h0);
        end
        key_raw = k6;
        t = cyc;
        expect_press(k6, t + LAT);
        tick(LAT - 1);
        chk("bounce_valid_early", 32'(key_valid), 32'h0);
        tick(1);
        chk("bounce_valid", 32'(key_valid), 32'h1);
        chk("bounce_bcd", 32'(bcd(key_onehot)), 32'd6);
        tick(4);
        key_raw = '0;
        tick(12);
        chk("bounce_drain", 32'(sb.size()), 32'd0);

        // Key 3: short drop, then sustained drop
        key_raw = k3;
        t = cyc;
        expect_press(k3, t + LAT);
        tick(10);
        key_raw = '0;
        tick(2);
        key_raw = k3;
        stay_ok = 1'b1;
        repeat (12) begin
            tick(1);
            if (!(key_valid && key_onehot == k3)) stay_ok = 1'b0;
        end
        chk("short_drop_hold", 32'(stay_ok), 32'h1);
        key_raw = '0;
        t = cyc;
        tick(LAT - 1);
        chk("drop_valid_early", 32'(key_valid), 32'h1);
        tick(1);
        chk("drop_valid", 32'(key_valid), 32'h0);
        chk("drop_onehot", 32'(key_onehot), 32'h0);
        tick(6);
        chk("drop_drain", 32'(sb.size()), 32'd0);

        // Rollover from key 3 to key 1 is not accepted
        key_raw = k3;
        t = cyc;
        expect_press(k3, t + LAT);
        tick(10);
        key_raw = k1;
        stay_ok = 1'b1;
        repeat (15) begin
            tick(1);
            if (!(key_valid && key_onehot == k3)) stay_ok = 1'b0;
        end
        chk("rollover_hold", 32'(stay_ok), 32'h1);
        key_raw = '0;
        t = cyc;
        tick(5);
        chk("rollover_rel_early", 32'(key_valid), 32'h1);
        tick(1);
        chk("rollover_rel", 32'(key_valid), 32'h0);
        tick(8);
        chk("rollover_drain", 32'(sb.size()), 32'd0);

        // Reset while key 4 is pressed
        key_raw = k4;
        t = cyc;
        expect_press(k4, t + LAT);
        tick(10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(key_valid), 32'h0);
        chk("midrst_onehot", 32'(key_onehot), 32'h0);
        tick(3);
        rst = 1'b0;
        t = cyc;
        expect_press(k4, t + LAT);
        tick(LAT - 1);
        chk("midrst_early", 32'(key_valid), 32'h0);
        tick(1);
        chk("midrst_valid_again", 32'(key_valid), 32'h1);
        chk("midrst_strobe", 32'(key_strobe), 32'h1);
        key_raw = '0;
        tick(12);
        chk("midrst_drain", 32'(sb.size()), 32'd0);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            t = cyc;
            key_raw = vecs[v].key;
            if (vecs[v].exp_oh != '0) expect_press(vecs[v].exp_oh, t + LAT);
            tick(vecs[v].hold);
            key_raw = '0;
            tick(12);
            chk("vec_idle", 32'(key_valid), 32'h0);
            chk("vec_drain", 32'(sb.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
